sub_nbit_serial: RTL and testbench

//  Bit-serial n-bit subtractor: Diff = in1 - in2 - Bin, computed LSB-first, one bit per clock.

---
 rtl/sub_nbit_serial_pkg.sv | 16 +
 rtl/sub_nbit_serial_fa.sv | 14 +
 rtl/sub_nbit_serial.sv | 125 ++++++++++++
 tb/tb_sub_nbit_serial.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sub_nbit_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state codes and
// the sizing helper for the bit counter.
package sub_nbit_serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // Counter must be able to hold WIDTH itself, so one extra bit over clog2.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/sub_nbit_serial_fa.sv
// Single-bit full adder cell; the serial subtractor feeds it an inverted
// subtrahend bit and treats the carry as not-borrow.
module FA_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sub_nbit_serial.sv
// Bit-serial n-bit subtractor: Diff = in1 - in2 - Bin, LSB first, one bit per
// clock through a single full-adder cell, behind a start/ready/done handshake.
module sub_nbit_serial
    import sub_nbit_serial_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             Bin,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             done
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             carry_q, carry_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_q, busy_q, done_q;

    logic             b_inv_s;
    logic             fa_sum_s;
    logic             fa_cout_s;

    assign b_inv_s = ~b_q[0];

    FA_1bit u_fa (
        .a   (a_q[0]),
        .b   (b_inv_s),
        .cin (carry_q),
        .sum (fa_sum_s),
        .cout(fa_cout_s)
    );

    // Next-state and datapath update for the serial subtract sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        carry_d = carry_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = in1;
                    b_d     = in2;
                    carry_d = ~Bin;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                // Result enters at the MSB so after WIDTH shifts bit 0 is aligned.
                a_d             = a_q >> 1'b1;
                b_d             = b_q >> 1'b1;
                diff_d          = diff_q >> 1'b1;
                diff_d[WIDTH-1] = fa_sum_s;
                carry_d         = fa_cout_s;
                cnt_d           = cnt_q + CW'(1'b1);
                if (cnt_q == LAST) begin
                    bout_d  = ~fa_cout_s;
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            carry_q <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            carry_q <= carry_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == S_IDLE);
            busy_q  <= (state_d == S_SHIFT) || (state_d == S_DONE);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign Diff  = diff_q;
    assign Bout  = bout_q;

endmodule

// File: tb/tb_sub_nbit_serial.sv
// Self-checking bench for sub_nbit_serial at WIDTH 4, 8 and 1 against an
// arithmetic reference model.
module tb_sub_nbit_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start_s = 3'b000;
    logic [7:0] in1_s = 8'd0;
    logic [7:0] in2_s = 8'd0;
    logic       bin_s = 1'b0;
    logic [2:0] ready_s, busy_s, done_s, bout_s;
    logic [3:0] diff4_s;
    logic [7:0] diff8_s;
    logic [0:0] diff1_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sub_nbit_serial #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start_s[0]), .in1(in1_s[3:0]), .in2(in2_s[3:0]),
        .Bin(bin_s), .ready(ready_s[0]), .busy(busy_s[0]), .Diff(diff4_s),
        .Bout(bout_s[0]), .done(done_s[0])
    );

    sub_nbit_serial #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start_s[1]), .in1(in1_s), .in2(in2_s),
        .Bin(bin_s), .ready(ready_s[1]), .busy(busy_s[1]), .Diff(diff8_s),
        .Bout(bout_s[1]), .done(done_s[1])
    );

    sub_nbit_serial #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[2]), .in1(in1_s[0:0]), .in2(in2_s[0:0]),
        .Bin(bin_s), .ready(ready_s[2]), .busy(busy_s[2]), .Diff(diff1_s),
        .Bout(bout_s[2]), .done(done_s[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int width_of(input int sel);
        return (sel == 0) ? 4 : (sel == 1) ? 8 : 1;
    endfunction

    function automatic logic [31:0] diff_of(input int sel);
        return (sel == 0) ? 32'(diff4_s) : (sel == 1) ? 32'(diff8_s) : 32'(diff1_s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on instance sel, checked against plain arithmetic.
    task automatic run_op(input int sel, input int a, input int b, input int bin);
        int          w;
        int          k;
        logic [31:0] exp_diff;
        logic [31:0] exp_bout;
        w        = width_of(sel);
        exp_diff = 32'((a - b - bin) & ((1 << w) - 1));
        exp_bout = (a < b + bin) ? 32'd1 : 32'd0;
        for (int i = 0; i < 20 && ready_s[sel] !== 1'b1; i++) tick();
        chk("ready_before_start", 32'(ready_s[sel]), 32'd1);
        in1_s = 8'(a);
        in2_s = 8'(b);
        bin_s = 1'(bin);
        start_s[sel] = 1'b1;
        tick();
        start_s[sel] = 1'b0;
        in1_s = 8'($urandom);
        in2_s = 8'($urandom);
        bin_s = 1'($urandom);
        chk("busy_after_accept", {30'd0, busy_s[sel], ready_s[sel]}, 32'd2);
        k = 0;
        while (done_s[sel] !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk("latency", 32'(k), 32'(w));
        chk("diff", diff_of(sel), exp_diff);
        chk("bout", 32'(bout_s[sel]), exp_bout);
        tick();
        chk("done_one_cycle", {30'd0, done_s[sel], ready_s[sel]}, 32'd1);
        chk("diff_held", diff_of(sel), exp_diff);
    endtask

    initial begin
        int k;
        tick();
        tick();
        chk("reset_ready", 32'(ready_s), 32'h7);
        chk("reset_busy", 32'(busy_s), 32'h0);
        chk("reset_done", 32'(done_s), 32'h0);
        chk("reset_diff4", 32'(diff4_s), 32'h0);
        chk("reset_bout", 32'(bout_s), 32'h0);
        rst = 1'b0;
        tick();

        run_op(0, 9, 3, 0);
        run_op(0, 3, 9, 0);
        run_op(0, 0, 0, 1);
        run_op(0, 15, 15, 0);

        // start held high, operands disturbed mid-operation
        in1_s = 8'd9; in2_s = 8'd3; bin_s = 1'b0;
        start_s[0] = 1'b1;
        tick();
        in1_s = 8'd5; in2_s = 8'd1;
        k = 0;
        while (done_s[0] !== 1'b1 && k < 40) begin tick(); k++; end
        chk("held_latency1", 32'(k), 32'd4);
        chk("held_diff1", 32'(diff4_s), 32'd6);
        tick();
        chk("held_idle_gap", {30'd0, done_s[0], ready_s[0]}, 32'd1);
        tick();
        chk("held_second_accept", 32'(busy_s[0]), 32'd1);
        start_s[0] = 1'b0;
        k = 0;
        while (done_s[0] !== 1'b1 && k < 40) begin tick(); k++; end
        chk("held_latency2", 32'(k), 32'd4);
        chk("held_diff2", 32'(diff4_s), 32'd4);
        tick();
        chk("held_done_pulse", 32'(done_s[0]), 32'd0);

        // reset during second SHIFT cycle
        in1_s = 8'd12; in2_s = 8'd5; bin_s = 1'b0;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        tick();
        chk("abort_no_done", 32'(done_s[0]), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_state", {28'd0, ready_s[0], busy_s[0], done_s[0], bout_s[0]}, 32'h8);
        chk("abort_diff", 32'(diff4_s), 32'd0);
        run_op(0, 7, 2, 0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    run_op(0, a, b, c);

        run_op(1, 200, 57, 0);
        run_op(2, 0, 1, 0);
        for (int i = 0; i < 40; i++)
            run_op(1, int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)));
        for (int i = 0; i < 16; i++)
            run_op(2, int'($urandom_range(1)), int'($urandom_range(1)), int'($urandom_range(1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
